maxpool_engine: RTL

Layer engine that answers the CNN controller's MAXPOOL run/done handshake. On a one-cycle `maxp_run` pulse it reads an IMG_H×IMG_W feature map from the input buffer and performs a 2×2, stride-2 signed max-pool. It writes the (IMG_H/2)×(IMG_W/2) result to the output buffer and returns a one-cycle `maxp_done` pulse. It sits between the activation memory and the controller, in the same slot as the conv, relu, fc and softmax engines.

---
 rtl/maxpool_if.sv | 27 ++
 rtl/maxpool_engine.sv | 115 +++++++++++
 2 files changed

// File: rtl/maxpool_if.sv
// Controller handshake plus input/output buffer ports of the max-pool engine.
// The engine connects through the slave modport; the controller/buffer side
// uses the master modport.
interface maxpool_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              maxp_run;
  logic              maxp_done;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    input  maxp_run, rd_data,
    output maxp_done, busy, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport master (
    output maxp_run, rd_data,
    input  maxp_done, busy, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/maxpool_engine.sv
// 2x2 stride-2 signed max-pool over an IMG_H x IMG_W feature map.
// Each output window costs 5 cycles: four reads (FETCH k=0..3) then one
// write-back cycle (WB) that folds in the last datum combinationally.
module maxpool_engine #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  maxpool_if.slave bus
);

  localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OW_A    = ADDR_W'(IMG_W / 2);
  localparam logic [ADDR_W-1:0] OW_LAST = ADDR_W'(IMG_W / 2 - 1);
  localparam logic [ADDR_W-1:0] OH_LAST = ADDR_W'(IMG_H / 2 - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WB, DONE} state_t;

  state_t                   state, state_nx;
  logic [1:0]               k;
  logic [ADDR_W-1:0]        orow, ocol;
  logic signed [DATA_W-1:0] acc;
  logic signed [DATA_W-1:0] rd_s;
  logic signed [DATA_W-1:0] wb_max;
  logic [ADDR_W-1:0]        base;
  logic                     last_win;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  assign rd_s     = $signed(bus.rd_data);
  assign wb_max   = smax(acc, rd_s);
  assign base     = ((orow << 1) * W_A) + (ocol << 1);
  assign last_win = (orow == OH_LAST) && (ocol == OW_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and the read-side/status outputs decoded from state.
  always_comb begin
    state_nx    = state;
    bus.busy    = (state != IDLE);
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    case (state)
      IDLE:  if (bus.maxp_run) state_nx = FETCH;
      FETCH: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = base + (k[1] ? W_A : '0) + ADDR_W'(k[0]);
        if (k == 2'd3) state_nx = WB;
      end
      WB:    state_nx = last_win ? DONE : FETCH;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Window counters, accumulator and registered write/done outputs.
  // NOTE: every register here uses <= so all of them see the pre-edge values
  // of state/k/acc; a blocking update would let later lines see new values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k             <= '0;
      orow          <= '0;
      ocol          <= '0;
      acc           <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.maxp_done <= 1'b0;
    end else begin
      bus.wr_en     <= 1'b0;
      bus.maxp_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.maxp_run) begin
            orow <= '0;
            ocol <= '0;
            k    <= '0;
          end
        end
        FETCH: begin
          k <= k + 2'd1;
          // Data lags the read by one cycle: k=1 sees the k=0 datum.
          if (k == 2'd1)      acc <= rd_s;
          else if (k != 2'd0) acc <= smax(acc, rd_s);
        end
        WB: begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= orow * OW_A + ocol;
          bus.wr_data <= wb_max;
          if (ocol == OW_LAST) begin
            ocol <= '0;
            orow <= last_win ? '0 : orow + 1'b1;
          end else begin
            ocol <= ocol + 1'b1;
          end
        end
        DONE: bus.maxp_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
